// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, parity modes and baud divider helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} uart_rx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the rx pad, resets to the idle-high level
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b11;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with valid/ready output and error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);
  localparam int BD = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(BD);
  localparam int BW = $clog2(DATA_BITS + 1);
  logic rx_s, smp;
  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d(rx), .q(rx_s));
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
  logic [1:0] hist;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist <= 2'b11;
    else hist <= {hist[0], rx_s};
  assign smp = (hist[1] & hist[0]) | (rx_s & (hist[1] | hist[0]));
`else
  localparam int MAJ = 0;
  assign smp = rx_s;
`endif
  // Later decisions count from the previous one, so the majority delay only shifts the start point
  localparam logic [CW-1:0] START_PT  = CW'(BD / 2 - 1 + MAJ);
  localparam logic [CW-1:0] BIT_PT    = CW'(BD - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  uart_rx_state_t       state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad, done, tick;
  assign tick = baud_cnt == (state == S_START ? START_PT : BIT_PT);
  assign busy = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bad     <= 1'b0;
      done        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      done        <= 1'b0;
      baud_cnt    <= tick ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: if (tick) begin
          state   <= smp ? S_IDLE : S_DATA;
          bit_cnt <= '0;
          par_bad <= 1'b0;
        end
        S_DATA: if (tick) begin
          shreg   <= {smp, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt == DATA_LAST ? '0 : bit_cnt + 1'b1;
          if (bit_cnt == DATA_LAST) state <= PARITY != PAR_NONE ? S_PARITY : S_STOP;
        end
        S_PARITY: if (tick) begin
          par_bad <= (^shreg ^ smp) != (PARITY == PAR_ODD);
          state   <= S_STOP;
        end
        S_STOP: if (tick) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (!smp) begin
            frame_err <= 1'b1;
            state     <= S_BREAK;
          end else if (bit_cnt == STOP_LAST) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_BREAK: if (rx_s) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (done && (!rx_valid || rx_ready)) begin
        rx_data    <= shreg;
        parity_err <= par_bad;
        rx_valid   <= 1'b1;
      end else if (done) overrun_err <= 1'b1;
      else if (rx_valid && rx_ready) rx_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed checks of an 8N1 and a 7E1 receiver at BAUD_DIV = 10
module tb_uart_rx_param;
  logic clk = 1'b0, rst_n;
  logic rx0, rx1, ready0, ready1;
  logic [7:0] rx_data0;
  logic [6:0] rx_data1;
  logic rx_valid0, parity_err0, frame_err0, overrun_err0, busy0;
  logic rx_valid1, parity_err1, frame_err1, overrun_err1, busy1;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int nacc0 = 0, nacc1 = 0, nfe0 = 0, noe0 = 0, nbusy0 = 0, t_acc0 = 0, t_start0 = 0;
  logic [7:0] cap0 = '0;
  logic [6:0] cap1 = '0;
  logic capp0 = 1'b0, capp1 = 1'b0;
  int b_acc, b_fe, b_oe, b_busy;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(ready0),
    .parity_err(parity_err0), .frame_err(frame_err0), .overrun_err(overrun_err0), .busy(busy0));

  uart_rx_param #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(ready1),
    .parity_err(parity_err1), .frame_err(frame_err1), .overrun_err(overrun_err1), .busy(busy1));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid0 && ready0) begin nacc0 <= nacc0 + 1; cap0 <= rx_data0; capp0 <= parity_err0; t_acc0 <= cyc; end
    if (rx_valid1 && ready1) begin nacc1 <= nacc1 + 1; cap1 <= rx_data1; capp1 <= parity_err1; end
    if (frame_err0) nfe0 <= nfe0 + 1;
    if (overrun_err0) noe0 <= noe0 + 1;
    if (busy0) nbusy0 <= nbusy0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic send(input bit which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) rx1 = bits[i]; else rx0 = bits[i];
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    idle(3);
    check("rst_valid0", rx_valid0, 0);
    check("rst_data0", rx_data0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_errs0", {frame_err0, overrun_err0, parity_err0}, 0);
    check("rst_valid1", rx_valid1, 0);
    rst_n = 1'b1;
    idle(5);
    // 8N1 0xA5
    t_start0 = cyc;
    send(0, {1'b1, 8'hA5, 1'b0}, 10);
    idle(10);
    check("a5_count", nacc0, 1);
    check("a5_data", cap0, 8'hA5);
    check("a5_perr", capp0, 0);
    check("a5_errs", nfe0 + noe0, 0);
    check("a5_latency", (t_acc0 - t_start0 >= 95) && (t_acc0 - t_start0 <= 106), 1);
    check("a5_busy", busy0, 0);
    // 7E1: 0x35 has four ones, so a parity bit of 1 is wrong; 0x4C has three, so 0 is wrong... use 1 (correct)
    send(1, {1'b1, 1'b1, 7'h35, 1'b0}, 10);
    idle(10);
    check("e35_count", nacc1, 1);
    check("e35_data", cap1, 7'h35);
    check("e35_perr", capp1, 1);
    send(1, {1'b1, 1'b1, 7'h4C, 1'b0}, 10);
    idle(10);
    check("e4c_count", nacc1, 2);
    check("e4c_data", cap1, 7'h4C);
    check("e4c_perr", capp1, 0);
    // Low stop bit followed by a held-low line
    b_acc = nacc0; b_fe = nfe0;
    send(0, 16'h0000, 10);
    idle(50);
    rx0 = 1'b1;
    idle(20);
    check("brk_fe_once", nfe0 - b_fe, 1);
    check("brk_no_word", nacc0 - b_acc, 0);
    check("brk_valid", rx_valid0, 0);
    send(0, {1'b1, 8'h3C, 1'b0}, 10);
    idle(10);
    check("brk_next_data", cap0, 8'h3C);
    check("brk_next_count", nacc0 - b_acc, 1);
    // 3-cycle glitch on the idle line
    b_acc = nacc0; b_fe = nfe0; b_busy = nbusy0;
    rx0 = 1'b0;
    idle(3);
    rx0 = 1'b1;
    idle(20);
    check("gl_saw_busy", nbusy0 != b_busy, 1);
    check("gl_busy_low", busy0, 0);
    check("gl_no_output", (nacc0 - b_acc) + (nfe0 - b_fe), 0);
    // Overrun with consumer stalled
    b_acc = nacc0; b_oe = noe0;
    ready0 = 1'b0;
    send(0, {1'b1, 8'h11, 1'b0}, 10);
    send(0, {1'b1, 8'h22, 1'b0}, 10);
    idle(5);
    check("ov_valid", rx_valid0, 1);
    check("ov_data", rx_data0, 8'h11);
    check("ov_pulse", noe0 - b_oe, 1);
    ready0 = 1'b1;
    idle(2);
    check("ov_drained", rx_valid0, 0);
    check("ov_taken", cap0, 8'h11);
    check("ov_count", nacc0 - b_acc, 1);
    // Asynchronous reset in the middle of a data field
    ready0 = 1'b0;
    send(0, {1'b1, 8'h77, 1'b0}, 10);
    idle(5);
    check("mr_pre_valid", rx_valid0, 1);
    rx0 = 1'b0;
    idle(40);
    check("mr_pre_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", rx_valid0, 0);
    check("mr_data", rx_data0, 0);
    check("mr_busy", busy0, 0);
    check("mr_errs", {frame_err0, overrun_err0, parity_err0}, 0);
    @(negedge clk);
    rx0 = 1'b1; ready0 = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    b_acc = nacc0;
    send(0, {1'b1, 8'h5A, 1'b0}, 10);
    idle(10);
    check("mr_next_data", cap0, 8'h5A);
    check("mr_next_count", nacc0 - b_acc, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART receiver and successor to the fixed 8N1 receiver.
- Configurable data width, parity and stop-bit count; input synchroniser; glitch-rejecting start detection.
- Holds each received word behind a valid/ready handshake and reports parity, framing and overrun errors.
- Sits between the rx pad and the command/FIFO layer.

Parameters:
- CLK_FREQ, 100000000, system clock in Hz.
- BAUD_RATE, 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division, BAUD_DIV >= 8 required).
- DATA_BITS, 8, data bits per frame, legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, stop bits checked, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  DATA_BITS  received word, LSB = first bit on line.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid && rx_ready on a rising clk edge.
- parity_err  out  1  parity mismatch for the word in rx_data; valid while rx_valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err  out  1  one-cycle pulse: frame completed while rx_valid was high and rx_ready was low.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, synchroniser flops = 1, rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun_err = 0, busy = 0, bit counter and baud counter = 0.
- rx passes through a 2-flop synchroniser (rx_s); all logic uses rx_s only.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s == 0 -> START, baud counter cleared.
- START: count to BAUD_DIV/2 - 1, then sample rx_s.
  - 0 -> DATA, counter cleared.
  - 1 -> IDLE (glitch rejected, nothing reported).
- DATA: sample at every BAUD_DIV-th count (mid-bit). Shift in LSB first. After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
- PARITY: one sample. Error when XOR of data bits ^ parity bit != (PARITY == 1).
- STOP: STOP_BITS samples, one bit period apart. Any stop sample == 0:
  - frame_err pulses for one cycle, word discarded, rx_valid unaffected.
  - go to BREAK.
- All stop samples == 1: word complete in the cycle after the final stop sample; return to IDLE in that same cycle. No wait for the end of the stop bit.
- Completion with rx_valid == 0, or with rx_valid && rx_ready in the same cycle: load rx_data and parity_err, set rx_valid = 1.
- Completion with rx_valid && !rx_ready: new word dropped, old word and its parity_err retained, overrun_err pulses for one cycle.
- rx_valid clears on handshake when no completion occurs in the same cycle.
- BREAK: stay until rx_s == 1, then IDLE. A held-low line or break produces exactly one frame_err.
- Start latency: the first data sample occurs 1.5*BAUD_DIV cycles (±1) after the synchronised falling edge, plus 2 synchroniser cycles.
- Counter widths: $clog2(BAUD_DIV) for the baud counter and $clog2(DATA_BITS+1) for the bit counter. No wrap-around occurs inside a frame.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: every start, data, parity and stop decision is the 2-of-3 majority of rx_s at mid-1, mid and mid+1 counts. The decision is taken at mid+1, so every sample point and completion shifts one cycle later.
- Undefined: single sample at mid; no extra registers.

Decomposition:
- Package uart_pkg: state enum (uart_rx_state_t), parity mode constants (PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2), function baud_div(CLK_FREQ, BAUD_RATE).
- One sub-module, uart_rx_sync: 2-flop synchroniser with reset value 1. Optional majority sampler stays in the top level.
- FSM, counters, shift register and handshake stay in uart_rx_param.

Test Plan:
Bench configuration for all scenarios: CLK_FREQ = 1000000, BAUD_RATE = 100000 (BAUD_DIV = 10), rx_ready held 1 unless stated.
- 8N1, byte 0xA5 -> rx_valid = 1 within 1 bit period after the start edge + 95 cycles; rx_data = 0xA5; no errors.
- DATA_BITS = 7, PARITY = 2, frame 0x35 with wrong parity bit -> rx_data = 0x35, parity_err = 1 with rx_valid.
- Stop bit driven low, line then held low for 50 cycles -> single frame_err pulse; rx_valid stays 0; next valid frame 0x3C is received correctly.
- 3-cycle low glitch on idle line -> no state change past START, busy drops, no outputs.
- rx_ready = 0, frames 0x11 then 0x22 -> rx_data stays 0x11, one overrun_err pulse; after ready, rx_valid drops.
- rst_n asserted mid-DATA -> all outputs 0 immediately; after release, frame 0x5A is received correctly.
